pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3, number of drain cycles before an ISA mode switch (legal range 1..7).
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 Rs1D, Rs2D  in  5 each  source registers of the instruction in D.
REQ-006 Rs1E, Rs2E, RdE  in  5 each  sources and destination of the instruction in E.
REQ-007 RdM, RdW  in  5 each  destinations in M and W.
REQ-008 RegWriteM, RegWriteW  in  1 each  register write pending in M and W.
REQ-009 ResultSrcE0  in  1  instruction in E is a load.
REQ-010 PCSrcE  in  1  taken branch or jump resolved in E.
REQ-011 armE  in  1  instruction in E is ARM (disables the x0 rule).
REQ-012 ModeSwitchD  in  1  instruction in D is an ISA mode switch.
REQ-013 MemReqM, MemReadyM  in  1 each  data-memory request and ready handshake.
REQ-014 StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
REQ-015 FlushD, FlushE, FlushW  out  1 each  bubble the corresponding pipeline register.
REQ-016 ForwardAE, ForwardBE  out  2 each  00 = register file, 10 = M result, 01 = W result.
REQ-017 ModeToggle  out  1  one-cycle pulse that flips the core ISA mode.
REQ-018 StallCount  out  16  saturating count of cycles in which StallF=1.

Function
REQ-019 Forwarding SHALL be combinational.
- ForwardAE = 10 when RegWriteM=1, RdM=Rs1E and (armE=1 or Rs1E!=0).
- Otherwise ForwardAE = 01 under the same test using W.
- Otherwise ForwardAE = 00.
- ForwardBE follows the same rules using Rs2E.
REQ-020 States SHALL be RUN, DRAIN and MEMWAIT, held in a registered state plus a 1-bit resume register (RUN or DRAIN).
REQ-021 Event priority (highest first) SHALL be: memory wait, taken branch, mode switch, load-use.
REQ-022 Memory wait SHALL be MemReqM=1 and MemReadyM=0, evaluated in any state.
- Response in the same cycle: StallF = StallD = StallE = StallM = 1, FlushW = 1, all other flushes 0.
- Next state is MEMWAIT; resume records the current state.
- The DRAIN counter is held.
REQ-023 MEMWAIT SHALL exit on the first cycle with MemReadyM=1.
- That cycle has no stalls and no FlushW.
- Next state is the resume state.
REQ-024 Taken branch: PCSrcE=1 in RUN or DRAIN SHALL assert FlushD = FlushE = 1 with no stalls.
- Next state is RUN.
- A pending DRAIN is aborted with no ModeToggle, because the switch instruction is wrong-path.
REQ-025 Mode-switch detection: RUN with ModeSwitchD=1 and no higher-priority event SHALL enter DRAIN.
- The counter loads DRAIN_CYCLES-1.
- This cycle asserts StallF = StallD = FlushE = 1.
REQ-026 DRAIN with counter>0 SHALL assert StallF = StallD = FlushE = 1 and decrement the counter.
REQ-027 DRAIN with counter=0 SHALL assert ModeToggle=1 with no stalls and no flushes.
- Next state is RUN.
REQ-028 Load-use: in RUN, ResultSrcE0=1, RdE!=0 (or armE=1) and RdE equal to Rs1D or Rs2D SHALL assert StallF = StallD = FlushE = 1 for that cycle only.
- State is unchanged.
REQ-029 Load-use coinciding with a taken branch SHALL produce the branch response only.
REQ-030 Load-use SHALL be ignored while in DRAIN, since D is already held.
REQ-031 StallCount SHALL increment on every cycle with StallF=1 and saturate at 16'hFFFF.
REQ-032 ModeToggle SHALL never be asserted outside the DRAIN counter=0 cycle.
REQ-033 ModeToggle SHALL never be high on two consecutive cycles.

Reset
REQ-034 rst=1 at a clock edge SHALL force the following, regardless of current state (including MEMWAIT and DRAIN mid-count):
- state RUN, resume RUN, counter 0, StallCount 0.
REQ-035 While rst=1, all stall, flush and ModeToggle outputs SHALL be 0 and ForwardAE/ForwardBE SHALL follow the combinational rules of REQ-019.

Verification
REQ-036 Forwarding: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1, armE=0 -> ForwardAE=10; then Rs1E=RdM=0 -> ForwardAE=00; then armE=1 -> ForwardAE=10.
REQ-037 Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> exactly one cycle of StallF=StallD=FlushE=1; StallCount increases by 1.
REQ-038 Drain: ModeSwitchD=1 with DRAIN_CYCLES=3 -> 3 cycles of StallF=StallD=FlushE=1, then one cycle of ModeToggle=1, then RUN.
REQ-039 Drain interrupted: MemReqM=1 and MemReadyM=0 for 4 cycles during drain cycle 2 -> 4 cycles of all-stall plus FlushW, then drain resumes and ModeToggle is asserted exactly one drain cycle later.
REQ-040 Branch abort: PCSrcE=1 during DRAIN -> FlushD=FlushE=1, RUN next, no ModeToggle ever; PCSrcE and load-use in the same cycle -> flushes only, StallF=0.
REQ-041 Saturation/reset: hold a memory wait for 70000 cycles -> StallCount=16'hFFFF; assert rst in MEMWAIT -> next cycle state RUN, StallCount=0, all stalls 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and pipeline-control unit for a five-stage core.
//
// Produces the per-stage stall and flush controls, the E-stage operand
// forwarding selects, a one-cycle pulse that flips the core ISA mode after
// a programmable drain, and a saturating count of fetch-stall cycles.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   Rs1D, Rs2D               source registers of the instruction in D
//   Rs1E, Rs2E, RdE          sources / destination of the instruction in E
//   RdM, RdW                 destinations in M and W
//   RegWriteM, RegWriteW     register write pending in M / W
//   ResultSrcE0              instruction in E is a load
//   PCSrcE                   taken branch or jump resolved in E
//   armE                     instruction in E is ARM (register 0 is a real register)
//   ModeSwitchD              instruction in D is an ISA mode switch
//   MemReqM, MemReadyM       data-memory request / ready handshake
//   StallF..StallM           hold the corresponding pipeline register
//   FlushD, FlushE, FlushW   bubble the corresponding pipeline register
//   ForwardAE, ForwardBE     00 register file, 10 M result, 01 W result
//   ModeToggle               one-cycle pulse that flips the ISA mode
//   StallCount               saturating count of cycles with StallF=1
module pipe_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        ResultSrcE0,
    input  logic        PCSrcE,
    input  logic        armE,
    input  logic        ModeSwitchD,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        ModeToggle,
    output logic [15:0] StallCount
);

    // Entry cycle counts as the first drain cycle, so load one less.
    localparam logic [2:0] DrainLoad = 3'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StMemWait
    } state_e;

    state_e      state_q, state_d;
    logic        resume_drain_q, resume_drain_d;  // 1: return to DRAIN after MEMWAIT
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] stall_count_q;

    logic mem_wait;
    logic load_use;

    // ---------------------------------------------------------------------
    // Forwarding
    // ---------------------------------------------------------------------
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (RdM == Rs1E) && (armE || (Rs1E != 5'd0))) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RdW == Rs1E) && (armE || (Rs1E != 5'd0))) begin
            ForwardAE = 2'b01;
        end
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM == Rs2E) && (armE || (Rs2E != 5'd0))) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RdW == Rs2E) && (armE || (Rs2E != 5'd0))) begin
            ForwardBE = 2'b01;
        end
    end

    // ---------------------------------------------------------------------
    // Control and next state
    // ---------------------------------------------------------------------
    assign mem_wait = MemReqM && !MemReadyM;
    assign load_use = ResultSrcE0 && (armE || (RdE != 5'd0)) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        StallF         = 1'b0;
        StallD         = 1'b0;
        StallE         = 1'b0;
        StallM         = 1'b0;
        FlushD         = 1'b0;
        FlushE         = 1'b0;
        FlushW         = 1'b0;
        ModeToggle     = 1'b0;
        state_d        = state_q;
        resume_drain_d = resume_drain_q;
        cnt_d          = cnt_q;

        if (mem_wait) begin
            {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
            state_d = StMemWait;
            // A repeated wait while already waiting keeps the original resume point.
            if (state_q != StMemWait) begin
                resume_drain_d = (state_q == StDrain);
            end
        end else begin
            unique case (state_q)
                StMemWait: begin
                    if (MemReadyM) begin
                        state_d = resume_drain_q ? StDrain : StRun;
                    end else begin
                        // No request and no ready: the access is still outstanding.
                        {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
                    end
                end
                StRun: begin
                    if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (ModeSwitchD) begin
                        {StallF, StallD, FlushE} = 3'b111;
                        state_d = StDrain;
                        cnt_d   = DrainLoad;
                    end else if (load_use) begin
                        {StallF, StallD, FlushE} = 3'b111;
                    end
                end
                StDrain: begin
                    if (PCSrcE) begin
                        // The switch instruction was wrong-path: abandon it silently.
                        FlushD  = 1'b1;
                        FlushE  = 1'b1;
                        state_d = StRun;
                        cnt_d   = 3'd0;
                    end else if (cnt_q != 3'd0) begin
                        {StallF, StallD, FlushE} = 3'b111;
                        cnt_d = cnt_q - 3'd1;
                    end else begin
                        ModeToggle = 1'b1;
                        state_d    = StRun;
                    end
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end

        if (rst) begin
            {StallF, StallD, StallE, StallM} = 4'b0000;
            {FlushD, FlushE, FlushW}         = 3'b000;
            ModeToggle                       = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StRun;
            resume_drain_q <= 1'b0;
            cnt_q          <= 3'd0;
            stall_count_q  <= 16'd0;
        end else begin
            state_q        <= state_d;
            resume_drain_q <= resume_drain_d;
            cnt_q          <= cnt_d;
            if (StallF && (stall_count_q != 16'hFFFF)) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
        end
    end

    assign StallCount = stall_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl (DRAIN_CYCLES = 3).
// Forwarding is driven from a vector table; control sequences are hand
// written, each cycle pushing its expected outputs onto a scoreboard that
// is popped and compared once the combinational outputs have settled.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, armE, ModeSwitchD;
    logic        MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ModeToggle;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCount;

    pipe_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .armE(armE),
        .ModeSwitchD(ModeSwitchD), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ModeToggle(ModeToggle), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    // Control vector order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ModeToggle}
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b1100_0100;
    localparam logic [7:0] C_MEM  = 8'b1111_0010;
    localparam logic [7:0] C_BR   = 8'b0000_1100;
    localparam logic [7:0] C_MT   = 8'b0000_0001;

    typedef struct {
        string       nm;
        logic [7:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] sc;
    } exp_t;

    typedef struct {
        string      nm;
        logic       rst;
        logic [4:0] rs1e, rs2e, rdm, rdw;
        logic       regwm, regww, arm;
        logic [1:0] fa, fb;
    } fvec_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] sc_exp = 16'd0;

    task automatic clr();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, armE, ModeSwitchD} = '0;
        {MemReqM, MemReadyM} = '0;
    endtask

    task automatic check_out();
        exp_t       e;
        logic [7:0] act;
        e   = sb.pop_front();
        act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ModeToggle};
        n_cmp++;
        if (act !== e.ctl || ForwardAE !== e.fa || ForwardBE !== e.fb ||
            StallCount !== e.sc) begin
            n_bad++;
            $display("FAIL %s: ctl=%b fa=%b fb=%b cnt=%h, required ctl=%b fa=%b fb=%b cnt=%h",
                     e.nm, act, ForwardAE, ForwardBE, StallCount, e.ctl, e.fa, e.fb, e.sc);
        end
    endtask

    // Called at a falling edge with inputs already applied; ends at the next falling edge.
    task automatic cyc(input string nm, input logic [7:0] ctl,
                       input logic [1:0] fa = 2'b00, input logic [1:0] fb = 2'b00);
        exp_t e;
        e.nm = nm; e.ctl = ctl; e.fa = fa; e.fb = fb; e.sc = sc_exp;
        sb.push_back(e);
        #2;
        check_out();
        if (rst) sc_exp = 16'd0;
        else if (ctl[7] && sc_exp != 16'hFFFF) sc_exp = sc_exp + 16'd1;
        @(negedge clk);
    endtask

    fvec_t fv[10];

    initial begin
        fv[0] = '{"fwd_m_rs1",   0, 5,  0, 5,  5, 1, 1, 0, 2'b10, 2'b00};
        fv[1] = '{"fwd_x0",      0, 0,  0, 0,  5, 1, 1, 0, 2'b00, 2'b00};
        fv[2] = '{"fwd_x0_arm",  0, 0,  0, 0,  5, 1, 1, 1, 2'b10, 2'b10};
        fv[3] = '{"fwd_w_rs2",   0, 3,  9, 4,  9, 1, 1, 0, 2'b00, 2'b01};
        fv[4] = '{"fwd_w_only",  0, 9,  9, 9,  9, 0, 1, 0, 2'b01, 2'b01};
        fv[5] = '{"fwd_no_wr",   0, 9,  9, 9,  9, 0, 0, 0, 2'b00, 2'b00};
        fv[6] = '{"fwd_m_prio",  0, 12, 12, 12, 12, 1, 1, 0, 2'b10, 2'b10};
        fv[7] = '{"fwd_w_x0arm", 0, 0,  0, 3,  0, 1, 1, 1, 2'b01, 2'b01};
        fv[8] = '{"fwd_w_x0",    0, 0,  0, 3,  0, 1, 1, 0, 2'b00, 2'b00};
        fv[9] = '{"fwd_in_rst",  1, 12, 12, 12, 12, 1, 1, 0, 2'b10, 2'b10};

        clr();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc("reset", C_NONE);
        rst = 1'b0;
        cyc("idle", C_NONE);

        // Forwarding table
        for (int i = 0; i < 10; i++) begin
            clr();
            rst = fv[i].rst;
            Rs1E = fv[i].rs1e; Rs2E = fv[i].rs2e; RdM = fv[i].rdm; RdW = fv[i].rdw;
            RegWriteM = fv[i].regwm; RegWriteW = fv[i].regww; armE = fv[i].arm;
            cyc(fv[i].nm, C_NONE, fv[i].fa, fv[i].fb);
        end
        rst = 1'b0;
        clr();

        // Load-use on Rs2D
        ResultSrcE0 = 1'b1; RdE = 7; Rs2D = 7;
        cyc("lu_rs2", C_LU);
        clr();
        cyc("lu_after", C_NONE);
        // Load to x0 without ARM is not a hazard; with ARM it is
        ResultSrcE0 = 1'b1; RdE = 0; Rs1D = 0;
        cyc("lu_x0", C_NONE);
        armE = 1'b1;
        cyc("lu_x0_arm", C_LU);
        clr();

        // Full drain: 3 stall cycles then one toggle; load-use ignored on the toggle cycle
        ModeSwitchD = 1'b1;
        cyc("drain_enter", C_LU);
        cyc("drain_2", C_LU);
        cyc("drain_3", C_LU);
        ModeSwitchD = 1'b0; ResultSrcE0 = 1'b1; RdE = 7; Rs1D = 7;
        cyc("drain_toggle", C_MT);
        clr();
        cyc("drain_run", C_NONE);

        // Drain interrupted by 4 cycles of memory wait in the second drain cycle
        ModeSwitchD = 1'b1;
        cyc("dint_enter", C_LU);
        cyc("dint_2", C_LU);
        MemReqM = 1'b1;
        for (int i = 0; i < 4; i++) cyc("dint_memwait", C_MEM);
        MemReadyM = 1'b1;
        cyc("dint_ready", C_NONE);
        MemReqM = 1'b0; MemReadyM = 1'b0;
        cyc("dint_resume", C_LU);
        ModeSwitchD = 1'b0;
        cyc("dint_toggle", C_MT);
        cyc("dint_run", C_NONE);

        // Branch aborts a pending drain: no toggle afterwards
        ModeSwitchD = 1'b1;
        cyc("babort_enter", C_LU);
        cyc("babort_2", C_LU);
        PCSrcE = 1'b1;
        cyc("babort_branch", C_BR);
        clr();
        for (int i = 0; i < 3; i++) cyc("babort_no_toggle", C_NONE);

        // Branch beats load-use and mode switch in RUN
        PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RdE = 7; Rs2D = 7;
        cyc("br_over_lu", C_BR);
        clr();
        PCSrcE = 1'b1; ModeSwitchD = 1'b1;
        cyc("br_over_msw", C_BR);
        clr();
        cyc("br_msw_after", C_NONE);

        // Memory wait beats branch; resumes to RUN
        MemReqM = 1'b1; PCSrcE = 1'b1;
        cyc("mem_over_br", C_MEM);
        PCSrcE = 1'b0; MemReadyM = 1'b1;
        cyc("mem_ready_run", C_NONE);
        clr();
        cyc("mem_run", C_NONE);

        // Reset mid-drain
        ModeSwitchD = 1'b1;
        cyc("rdrain_enter", C_LU);
        rst = 1'b1;
        cyc("rdrain_rst", C_NONE);
        rst = 1'b0; ModeSwitchD = 1'b0;
        cyc("rdrain_run", C_NONE);

        // Saturation then reset while in MEMWAIT
        MemReqM = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            if (sc_exp != 16'hFFFF) sc_exp = sc_exp + 16'd1;
            @(negedge clk);
        end
        rst = 1'b1;
        cyc("sat_rst", C_NONE);
        rst = 1'b0; MemReqM = 1'b0;
        cyc("sat_after_rst", C_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
